// File: rtl/lanczos_fir6_pkg.sv
// rtl/lanczos_fir6_pkg.sv - shared scaler constants and width formulas
package lanczos_fir6_pkg;

   localparam int LATENCY = 5;

   function automatic int coe_frac_default(input int coe_width);
      return coe_width - 2;
   endfunction

   function automatic int prod_width(input int pixel_width, input int coe_width);
      return pixel_width + 1 + coe_width;
   endfunction

   // Six products plus rounding term cannot overflow with 4 guard bits.
   function automatic int acc_width(input int pixel_width, input int coe_width);
      return pixel_width + coe_width + 4;
   endfunction

endpackage

// File: rtl/lanczos_fir6_if.sv
// rtl/lanczos_fir6_if.sv - window/coefficient input and filtered pixel output bundle
interface lanczos_fir6_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int COE_WIDTH   = 10,
   parameter int USER_WIDTH  = 2
);
   logic [PIXEL_WIDTH-1:0] p0_i, p1_i, p2_i, p3_i, p4_i, p5_i;
   logic                   vld_i;
   logic [USER_WIDTH-1:0]  user_i;
   logic [COE_WIDTH-1:0]   coe0_i, coe1_i, coe2_i, coe3_i, coe4_i, coe5_i;
   logic [PIXEL_WIDTH-1:0] pix_o;
   logic                   vld_o;
   logic [USER_WIDTH-1:0]  user_o;
   logic                   clip_o;

   modport master (
      output p0_i, p1_i, p2_i, p3_i, p4_i, p5_i, vld_i, user_i,
      output coe0_i, coe1_i, coe2_i, coe3_i, coe4_i, coe5_i,
      input  pix_o, vld_o, user_o, clip_o
   );

   modport slave (
      input  p0_i, p1_i, p2_i, p3_i, p4_i, p5_i, vld_i, user_i,
      input  coe0_i, coe1_i, coe2_i, coe3_i, coe4_i, coe5_i,
      output pix_o, vld_o, user_o, clip_o
   );
endinterface

// File: rtl/lanczos_mul_pair.sv
// rtl/lanczos_mul_pair.sv - two pixel*coefficient products (S1) and their sum (S2)
module lanczos_mul_pair
   import lanczos_fir6_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int COE_WIDTH   = 10,
   localparam int PROD_W     = prod_width(PIXEL_WIDTH, COE_WIDTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PIXEL_WIDTH-1:0]      pix_a,
   input  logic [PIXEL_WIDTH-1:0]      pix_b,
   input  logic signed [COE_WIDTH-1:0] coe_a,
   input  logic signed [COE_WIDTH-1:0] coe_b,
   output logic signed [PROD_W:0]      sum
);

   logic signed [PROD_W-1:0] pix_a_x, pix_b_x, coe_a_x, coe_b_x;
   logic signed [PROD_W-1:0] prod_a, prod_b;

   // Pixels are unsigned: zero-extend so the product stays signed-correct.
   assign pix_a_x = {{(COE_WIDTH+1){1'b0}}, pix_a};
   assign pix_b_x = {{(COE_WIDTH+1){1'b0}}, pix_b};
   assign coe_a_x = {{(PIXEL_WIDTH+1){coe_a[COE_WIDTH-1]}}, coe_a};
   assign coe_b_x = {{(PIXEL_WIDTH+1){coe_b[COE_WIDTH-1]}}, coe_b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_a <= '0;
         prod_b <= '0;
         sum    <= '0;
      end else begin
         prod_a <= pix_a_x * coe_a_x;
         prod_b <= pix_b_x * coe_b_x;
         sum    <= {prod_a[PROD_W-1], prod_a} + {prod_b[PROD_W-1], prod_b};
      end
   end

endmodule

// File: rtl/lanczos_fir6.sv
// rtl/lanczos_fir6.sv - 6-tap Lanczos FIR, 5-stage free-running pipeline
// with round-half-up and clamp to the pixel range.
module lanczos_fir6
   import lanczos_fir6_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int COE_WIDTH   = 10,
   parameter int COE_FRAC    = coe_frac_default(COE_WIDTH),
   parameter int USER_WIDTH  = 2
) (
   input  logic          clk,
   input  logic          rst,
   lanczos_fir6_if.slave bus
);

   localparam int PROD_W = prod_width(PIXEL_WIDTH, COE_WIDTH);
   localparam int PAIR_W = PROD_W + 1;
   localparam int ACC_W  = acc_width(PIXEL_WIDTH, COE_WIDTH);
   localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) <<< (COE_FRAC - 1);

   logic [PIXEL_WIDTH-1:0]      p_s0 [6];
   logic signed [COE_WIDTH-1:0] coe [6];
   logic signed [PAIR_W-1:0]    pair_sum [3];
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     shifted;
   logic [PIXEL_WIDTH-1:0]      pix_next, pix_q;
   logic                        clip_next, clip_q;
   logic [LATENCY-1:0]          vld_pipe;
   logic [USER_WIDTH-1:0]       user_pipe [LATENCY];

   assign coe[0] = bus.coe0_i;
   assign coe[1] = bus.coe1_i;
   assign coe[2] = bus.coe2_i;
   assign coe[3] = bus.coe3_i;
   assign coe[4] = bus.coe4_i;
   assign coe[5] = bus.coe5_i;

   // S0 holds the window for one clock so it meets the ROM output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 6; k++) p_s0[k] <= '0;
      end else begin
         p_s0[0] <= bus.p0_i;
         p_s0[1] <= bus.p1_i;
         p_s0[2] <= bus.p2_i;
         p_s0[3] <= bus.p3_i;
         p_s0[4] <= bus.p4_i;
         p_s0[5] <= bus.p5_i;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_pair
      lanczos_mul_pair #(
         .PIXEL_WIDTH (PIXEL_WIDTH),
         .COE_WIDTH   (COE_WIDTH)
      ) u_pair (
         .clk   (clk),
         .rst   (rst),
         .pix_a (p_s0[2*g]),
         .pix_b (p_s0[2*g+1]),
         .coe_a (coe[2*g]),
         .coe_b (coe[2*g+1]),
         .sum   (pair_sum[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else begin
         acc <= {{(ACC_W-PAIR_W){pair_sum[0][PAIR_W-1]}}, pair_sum[0]}
              + {{(ACC_W-PAIR_W){pair_sum[1][PAIR_W-1]}}, pair_sum[1]}
              + {{(ACC_W-PAIR_W){pair_sum[2][PAIR_W-1]}}, pair_sum[2]}
              + ROUND;
      end
   end

   assign shifted = acc >>> COE_FRAC;

   always_comb begin
      pix_next  = shifted[PIXEL_WIDTH-1:0];
      clip_next = 1'b0;
      if (shifted[ACC_W-1]) begin
         pix_next  = '0;
         clip_next = 1'b1;
      end else if (|shifted[ACC_W-2:PIXEL_WIDTH]) begin
         pix_next  = '1;
         clip_next = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_q  <= '0;
         clip_q <= 1'b0;
      end else begin
         pix_q  <= pix_next;
         clip_q <= clip_next;
      end
   end

   // Tags advance only alongside valid samples, so user_o never shows idle data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         for (int k = 0; k < LATENCY; k++) user_pipe[k] <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LATENCY-2:0], bus.vld_i};
         if (bus.vld_i) user_pipe[0] <= bus.user_i;
         for (int k = 1; k < LATENCY; k++) begin
            if (vld_pipe[k-1]) user_pipe[k] <= user_pipe[k-1];
         end
      end
   end

   assign bus.pix_o  = pix_q;
   assign bus.clip_o = clip_q;
   assign bus.vld_o  = vld_pipe[LATENCY-1];
   assign bus.user_o = user_pipe[LATENCY-1];

endmodule

// File: tb/tb_lanczos_fir6.sv
// tb/tb_lanczos_fir6.sv - directed-vector bench for lanczos_fir6
module tb_lanczos_fir6;

   typedef logic [5:0][7:0] pix_arr_t;
   typedef logic [5:0][9:0] coe_arr_t;
   typedef struct packed {
      pix_arr_t   p;
      coe_arr_t   c;
      logic [7:0] pix;
      logic       clip;
   } vec_t;
   typedef struct packed {
      logic [7:0] pix;
      logic       clip;
      logic [1:0] user;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lanczos_fir6_if #(.PIXEL_WIDTH(8), .COE_WIDTH(10), .USER_WIDTH(2)) bus ();

   lanczos_fir6 #(
      .PIXEL_WIDTH (8),
      .COE_WIDTH   (10),
      .COE_FRAC    (8),
      .USER_WIDTH  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t     exp_q [$];
   logic [4:0] hist = '0;
   coe_arr_t coe_dly = '0;
   int       n_cmp = 0;
   int       n_bad = 0;
   vec_t     tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input pix_arr_t p, input coe_arr_t c, input logic [1:0] u);
      longint acc;
      longint sh;
      exp_t   e;
      acc = 128;
      for (int i = 0; i < 6; i++) acc += longint'(p[i]) * longint'($signed(c[i]));
      sh = acc >>> 8;
      e.user = u;
      if (sh < 0) begin
         e.pix = 8'd0; e.clip = 1'b1;
      end else if (sh > 255) begin
         e.pix = 8'd255; e.clip = 1'b1;
      end else begin
         e.pix = sh[7:0]; e.clip = 1'b0;
      end
      return e;
   endfunction

   // One clock: check outputs of the edge just passed, then drive this cycle.
   // Coefficients lag the window by one clock, as from the ROM.
   task automatic apply(input pix_arr_t p, input coe_arr_t c, input logic v,
                        input logic [1:0] u, input exp_t e);
      exp_t got;
      @(posedge clk);
      #1;
      check("vld_o", 32'(bus.vld_o), 32'(hist[4]));
      if (bus.vld_o) begin
         check("exp_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("pix_o", 32'(bus.pix_o), 32'(got.pix));
            check("clip_o", 32'(bus.clip_o), 32'(got.clip));
            check("user_o", 32'(bus.user_o), 32'(got.user));
         end
      end
      bus.p0_i = p[0]; bus.p1_i = p[1]; bus.p2_i = p[2];
      bus.p3_i = p[3]; bus.p4_i = p[4]; bus.p5_i = p[5];
      bus.vld_i  = v;
      bus.user_i = u;
      bus.coe0_i = coe_dly[0]; bus.coe1_i = coe_dly[1]; bus.coe2_i = coe_dly[2];
      bus.coe3_i = coe_dly[3]; bus.coe4_i = coe_dly[4]; bus.coe5_i = coe_dly[5];
      coe_dly = c;
      hist = {hist[3:0], v};
      if (v) exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) apply('0, '0, 1'b0, 2'd0, '0);
   endtask

   task automatic send_vec(input vec_t v, input logic [1:0] u);
      exp_t e;
      e.pix = v.pix; e.clip = v.clip; e.user = u;
      apply(v.p, v.c, 1'b1, u, e);
   endtask

   initial begin
      pix_arr_t p;
      coe_arr_t c;
      logic [1:0] u;

      for (int i = 0; i < 12; i++) tbl[i] = '0;
      tbl[0].c[2] = 10'd256; tbl[0].p[2] = 8'h5A; tbl[0].pix = 8'h5A;
      tbl[1].c[2] = 10'd128; tbl[1].c[3] = 10'd128; tbl[1].p[2] = 8'd3; tbl[1].p[3] = 8'd4;
      tbl[1].pix = 8'd4;
      tbl[2].c[0] = 10'h3C0; tbl[2].c[2] = 10'd256; tbl[2].p[0] = 8'd255;
      tbl[2].pix = 8'd0; tbl[2].clip = 1'b1;
      tbl[3].c[1] = 10'h3C0; tbl[3].c[2] = 10'd320; tbl[3].p[2] = 8'd255;
      tbl[3].pix = 8'd255; tbl[3].clip = 1'b1;
      tbl[4].p = {6{8'hFF}};
      tbl[5].c[2] = 10'd128; tbl[5].p[2] = 8'd1; tbl[5].pix = 8'd1;
      tbl[6].c[0] = 10'h380; tbl[6].p[0] = 8'd1;
      tbl[7].c[0] = 10'h300; tbl[7].p[0] = 8'd1; tbl[7].clip = 1'b1;
      tbl[8].c[2] = 10'd256; tbl[8].p[2] = 8'd255; tbl[8].pix = 8'd255;
      tbl[9].c[2] = 10'd256; tbl[9].p[2] = 8'd255; tbl[9].c[3] = 10'd128; tbl[9].p[3] = 8'd1;
      tbl[9].pix = 8'd255; tbl[9].clip = 1'b1;
      tbl[10].c[0] = 10'h380; tbl[10].p[0] = 8'd1; tbl[10].c[2] = 10'd256; tbl[10].p[2] = 8'd5;
      tbl[10].pix = 8'd5;
      tbl[11].c = {10'h3E0, 10'h3F8, 10'd40, 10'd224, 10'd40, 10'h3F8};
      tbl[11].p = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
      tbl[11].pix = 8'd26;

      bus.p0_i = '0; bus.p1_i = '0; bus.p2_i = '0; bus.p3_i = '0; bus.p4_i = '0; bus.p5_i = '0;
      bus.coe0_i = '0; bus.coe1_i = '0; bus.coe2_i = '0;
      bus.coe3_i = '0; bus.coe4_i = '0; bus.coe5_i = '0;
      bus.vld_i = 1'b0; bus.user_i = '0;

      idle(3);
      check("reset pix_o", 32'(bus.pix_o), 32'd0);
      check("reset clip_o", 32'(bus.clip_o), 32'd0);
      check("reset user_o", 32'(bus.user_o), 32'd0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 12; i++) begin
         send_vec(tbl[i], 2'(i));
         idle(6);
      end

      for (int i = 0; i < 12; i++) send_vec(tbl[i], 2'(i));
      idle(6);

      u = 2'd0;
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 6; k++) begin
            p[k] = 8'($urandom_range(0, 255));
            c[k] = 10'($urandom_range(0, 1023));
         end
         apply(p, c, 1'b1, u, model(p, c, u));
         u = u + 2'd1;
         idle($urandom_range(0, 2));
      end
      idle(6);
      check("stream drained", 32'(exp_q.size()), 32'd0);

      send_vec(tbl[0], 2'd3);
      idle(6);
      for (int i = 0; i < 3; i++) begin
         p = '0; c = '0;
         p[2] = 8'(40 + i); c[2] = 10'd256;
         apply(p, c, 1'b1, 2'(i + 1), model(p, c, 2'(i + 1)));
      end
      #2 rst = 1'b1;
      #1;
      check("rst vld_o", 32'(bus.vld_o), 32'd0);
      check("rst pix_o", 32'(bus.pix_o), 32'd0);
      check("rst clip_o", 32'(bus.clip_o), 32'd0);
      check("rst user_o", 32'(bus.user_o), 32'd0);
      hist = '0;
      exp_q.delete();
      idle(2);
      rst = 1'b0;
      idle(6);
      send_vec(tbl[1], 2'd2);
      idle(6);
      check("final drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lanczos_fir6.md
LANCZOS_FIR6 -- requirements
Module: lanczos_fir6

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, unsigned pixel sample width.
REQ-002 SHALL have parameter COE_WIDTH, default 10, signed two's-complement coefficient width.
REQ-003 SHALL have parameter COE_FRAC, default COE_WIDTH-2, coefficient fractional bits (1.0 = 2^COE_FRAC).
REQ-004 SHALL have parameter USER_WIDTH, default 2, sideband tag width (e.g. sol/eol).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports p0_i..p5_i  input  PIXEL_WIDTH each  6-tap pixel window, p0 leftmost.
REQ-008 SHALL have port vld_i  input  1  window valid, same cycle as dx driven to coefficient ROM.
REQ-009 SHALL have port user_i  input  USER_WIDTH  sideband tag qualified by vld_i.
REQ-010 SHALL have ports coe0_i..coe5_i  input  COE_WIDTH each  coefficients from ROM, one clock after dx.
REQ-011 SHALL have port pix_o  output  PIXEL_WIDTH  filtered, rounded, clamped pixel.
REQ-012 SHALL have port vld_o  output  1  pix_o/user_o/clip_o valid.
REQ-013 SHALL have port user_o  output  USER_WIDTH  user_i delayed to align with pix_o.
REQ-014 SHALL have port clip_o  output  1  result was clamped (either bound), qualified by vld_o.

Function
REQ-015 SHALL be a free-running pipeline, no backpressure; one result per valid input, order preserved, gaps preserved.
REQ-016 Stage S0 SHALL register p0..p5, vld_i, user_i, absorbing the 1-cycle ROM latency so coe*_i and S0 data align.
REQ-017 Stage S1 SHALL register six signed products pk * coek, pixel zero-extended by 1 bit; product width PIXEL_WIDTH+1+COE_WIDTH.
REQ-018 Stage S2 SHALL register three pair sums (0+1, 2+3, 4+5), each 1 bit wider than a product.
REQ-019 Stage S3 SHALL register the total sum of the three pairs plus rounding constant 2^(COE_FRAC-1); accumulator width PIXEL_WIDTH+COE_WIDTH+4, no internal overflow possible.
REQ-020 Stage S4 SHALL arithmetic-shift right by COE_FRAC, clamp to [0, 2^PIXEL_WIDTH-1], register pix_o, clip_o.
REQ-021 Latency SHALL be exactly 5 clocks from vld_i high to corresponding vld_o high.
REQ-022 Rounding SHALL be round-half-up on the signed sum (x.5 rounds toward +inf).
REQ-023 clip_o SHALL be 1 iff shifted sum <0 or >2^PIXEL_WIDTH-1; pix_o then 0 or max respectively.
REQ-024 Data registers MAY update on invalid cycles; vld_o, user_o SHALL follow only the valid pipeline.
REQ-025 Coefficient sum other than 1.0 SHALL be processed without special handling (clamp covers out-of-range).

Reset
REQ-026 rst SHALL asynchronously clear all valid-pipeline bits, pix_o, user_o, clip_o, vld_o to 0.
REQ-027 Samples in flight at rst assertion SHALL be discarded; none SHALL emerge after release.
REQ-028 First vld_i after rst deassertion SHALL produce vld_o exactly 5 clocks later.

Structure
REQ-029 COE_FRAC default, pipeline latency constant (5), and accumulator-width formula SHALL live in the shared scaler package/header.
REQ-030 One sub-module SHALL be natural: lanczos_mul_pair (two products + pair sum, S1-S2), instantiated three times.

Verification (PIXEL_WIDTH=8, COE_WIDTH=10, COE_FRAC=8)
REQ-031 Identity: coe2=256, others 0, p2=0x5A, vld_i pulse -> pix_o=0x5A, clip_o=0, vld_o exactly 5 clocks later.
REQ-032 Rounding: coe2=128, coe3=128, p2=3, p3=4 -> sum 3.5 -> pix_o=4, clip_o=0.
REQ-033 Low clamp: coe0=-64 (0x3C0), coe2=256, p0=255, p2=0 -> pix_o=0, clip_o=1.
REQ-034 High clamp: coe1=-64, coe2=320, p1=0, p2=255 -> 319 -> pix_o=255, clip_o=1.
REQ-035 Stream: 16 random windows with random vld_i gaps, user_i incrementing -> vld_o pattern identical, delayed 5, user_o order intact, pix_o matching reference model.
REQ-036 Reset mid-stream: assert rst with 3 samples in flight -> vld_o=0 immediately; no vld_o until 5 clocks after next vld_i.
